// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default timing shared by the UART transmit and receive sides.
package uart_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} uart_state_t;
    localparam int DEFAULT_CLK_FREQ = 100_000_000;
    localparam int DEFAULT_BAUD = 9600;
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/uart_tx_drain_if.sv
// uart_tx_drain_if: upstream fifo read side plus the serial outputs of the transmitter.
interface uart_tx_drain_if;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_pop;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    modport master (input fifo_empty, fifo_rdata, output fifo_pop, tx, tx_busy, tx_done);
    modport slave (output fifo_empty, fifo_rdata, input fifo_pop, tx, tx_busy, tx_done);
endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: one-cycle tick every BAUD_DIV clocks, restartable from zero via clear.
module baud_tick_gen #(
    parameter int BAUD_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int W = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(BAUD_DIV - 1);
    always_ff @(posedge clk)
        cnt <= (rst || clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous 8-bit fifo whose head data is visible combinationally while not empty.
module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign pop_data = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) begin
                mem[wp[AW-1:0]] <= push_data;
                wp <= wp + 1'b1;
            end
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pulls bytes from an upstream fifo and sends each as an 8N1 frame on tx.
module uart_tx_drain import uart_pkg::*; #(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD = DEFAULT_BAUD
) (
    input logic clk,
    input logic rst,
    uart_tx_drain_if.master bus
);
    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    uart_state_t state;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic tick, pop;
    // The pop edge is also the edge that latches the byte and starts the frame.
    assign pop = state == IDLE && !bus.fifo_empty && !rst;
    assign bus.fifo_pop = pop;
    baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (.clk(clk), .rst(rst), .clear(pop), .tick(tick));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            bit_idx <= '0;
            bus.tx <= 1'b1;
            bus.tx_busy <= 1'b0;
            bus.tx_done <= 1'b0;
        end else begin
            bus.tx_done <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    state <= START;
                    shreg <= bus.fifo_rdata;
                    bit_idx <= '0;
                    bus.tx <= 1'b0;
                    bus.tx_busy <= 1'b1;
                end
                START: if (tick) begin
                    state <= DATA;
                    bus.tx <= shreg[0];
                    shreg <= shreg >> 1;
                end
                DATA: if (tick) begin
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state <= STOP;
                        bus.tx <= 1'b1;
                    end else begin
                        bus.tx <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                STOP: if (tick) begin
                    state <= IDLE;
                    bus.tx_busy <= 1'b0;
                    bus.tx_done <= 1'b1;
                end
            endcase
        end
    end
endmodule
